// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB4 master port between NoRequesters requesters.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int NoRequesters  = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NoRequesters-1:0]                req_valid_i,
    output logic [NoRequesters-1:0]                req_ready_o,
    input  logic [NoRequesters*AddrWidth-1:0]      req_addr_i,
    input  logic [NoRequesters-1:0]                req_write_i,
    input  logic [NoRequesters*DataWidth-1:0]      req_wdata_i,
    input  logic [NoRequesters*(DataWidth/8)-1:0]  req_strb_i,
    input  logic [NoRequesters*3-1:0]              req_prot_i,
    output logic [NoRequesters-1:0]                rsp_valid_o,
    output logic [DataWidth-1:0]                   rsp_rdata_o,
    output logic                                   rsp_slverr_o,
    output logic [AddrWidth-1:0]                   paddr_o,
    output logic [2:0]                             pprot_o,
    output logic                                   psel_o,
    output logic                                   penable_o,
    output logic                                   pwrite_o,
    output logic [DataWidth-1:0]                   pwdata_o,
    output logic [DataWidth/8-1:0]                 pstrb_o,
    input  logic                                   pready_i,
    input  logic [DataWidth-1:0]                   prdata_i,
    input  logic                                   pslverr_i
);
    // state  | meaning
    // IDLE   | waiting for a request; grant is combinational
    // SETUP  | APB setup phase (psel=1, penable=0)
    // ACCESS | APB access phase, waiting for pready

    localparam int IdxWidth  = $clog2(NoRequesters);
    localparam int StrbWidth = DataWidth / 8;

    if (NoRequesters < 2 || (DataWidth % 8) != 0 || TimeoutCycles < 1) begin : g_bad_params
        $error("apb_rr_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [IdxWidth-1:0]     last_q, idx_q, grant_idx, cand;
    logic                    grant_found, accept, xfer_done, xfer_timeout;
    logic [AddrWidth-1:0]    addr_q;
    logic                    write_q;
    logic [DataWidth-1:0]    wdata_q, rdata_q;
    logic [StrbWidth-1:0]    strb_q;
    logic [2:0]              prot_q;
    logic [NoRequesters-1:0] rsp_valid_q;
    logic                    slverr_q;

    // Search starts just after the last winner and wraps.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = last_q;
        for (int i = 1; i <= NoRequesters; i++) begin
            cand = IdxWidth'((int'(last_q) + i) % NoRequesters);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept    = (state_q == IDLE) && grant_found && !rst_i;
    assign xfer_done = (state_q == ACCESS) && pready_i;

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[grant_idx] = 1'b1;
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TmoRaw   = $clog2(TimeoutCycles + 1);
    localparam int TmoWidth = (TmoRaw < 8) ? 8 : ((TmoRaw > 32) ? 32 : TmoRaw);

    logic [TmoWidth-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == SETUP) tmo_cnt_q <= '0;
        else if (state_q == ACCESS && !pready_i) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    // pready wins over a timeout landing in the same cycle.
    assign xfer_timeout = (state_q == ACCESS) && !pready_i &&
                          (tmo_cnt_q == TmoWidth'(TimeoutCycles - 1));
`else
    assign xfer_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (xfer_done || xfer_timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= IdxWidth'(NoRequesters - 1);
            idx_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            prot_q      <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            slverr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (accept) begin
                last_q  <= grant_idx;
                idx_q   <= grant_idx;
                addr_q  <= req_addr_i[int'(grant_idx)*AddrWidth +: AddrWidth];
                write_q <= req_write_i[grant_idx];
                prot_q  <= req_prot_i[int'(grant_idx)*3 +: 3];
                wdata_q <= req_write_i[grant_idx] ?
                           req_wdata_i[int'(grant_idx)*DataWidth +: DataWidth] : '0;
                strb_q  <= req_write_i[grant_idx] ?
                           req_strb_i[int'(grant_idx)*StrbWidth +: StrbWidth] : '0;
            end
            if (xfer_done) begin
                rsp_valid_q[idx_q] <= 1'b1;
                rdata_q            <= write_q ? '0 : prdata_i;
                slverr_q           <= pslverr_i;
            end else if (xfer_timeout) begin
                rsp_valid_q[idx_q] <= 1'b1;
                rdata_q            <= '0;
                slverr_q           <= 1'b1;
            end
        end
    end

    assign psel_o       = (state_q != IDLE);
    assign penable_o    = (state_q == ACCESS);
    assign paddr_o      = addr_q;
    assign pwrite_o     = write_q;
    assign pwdata_o     = wdata_q;
    assign pstrb_o      = strb_q;
    assign pprot_o      = prot_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_slverr_o = slverr_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios followed by randomized traffic
// against a transaction-level round-robin model. Honours APB_ARB_TIMEOUT_EN.
module tb_apb_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N*SW-1:0]   req_strb_i;
    logic [N*3-1:0]    req_prot_i;
    logic [DW-1:0]     rsp_rdata_o, pwdata_o, prdata_i;
    logic              rsp_slverr_o, psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
    logic [AW-1:0]     paddr_o;
    logic [2:0]        pprot_o;
    logic [SW-1:0]     pstrb_o;

    apb_rr_arbiter #(
        .NoRequesters(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .req_prot_i(req_prot_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_slverr_o(rsp_slverr_o), .paddr_o(paddr_o), .pprot_o(pprot_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i),
        .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int last_model;
    int post_mode;   // after handshake: 0 drop winner, 1 keep all, 2 drop all, 3 random

    logic [N-1:0]  rq_valid, rq_write;
    logic [AW-1:0] rq_addr  [N];
    logic [DW-1:0] rq_wdata [N];
    logic [SW-1:0] rq_strb  [N];
    logic [2:0]    rq_prot  [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            req_addr_i[k*AW +: AW]  = rq_addr[k];
            req_wdata_i[k*DW +: DW] = rq_wdata[k];
            req_strb_i[k*SW +: SW]  = rq_strb[k];
            req_prot_i[k*3 +: 3]    = rq_prot[k];
        end
        req_write_i = rq_write;
        req_valid_i = rq_valid;
    endtask

    task automatic rand_req(input int k);
        rq_addr[k]  = $urandom;
        rq_write[k] = 1'($urandom_range(0, 1));
        rq_wdata[k] = $urandom;
        rq_strb[k]  = SW'($urandom);
        rq_prot[k]  = 3'($urandom);
    endtask

    task automatic set_req(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
        rq_addr[k]  = a;
        rq_write[k] = wr;
        rq_wdata[k] = d;
        rq_strb[k]  = 4'hF;
        rq_prot[k]  = 3'($urandom);
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_model + k) % N;
            if (rq_valid[c]) return c;
        end
        return -1;
    endfunction

    // Runs one transfer starting in an IDLE cycle with inputs already applied;
    // returns in the response cycle with the new inputs applied.
    task automatic do_xfer(input int w, input int waits, input logic err, input logic [31:0] rd);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic [2:0]    ep;
        logic          ew;
        ea = rq_addr[w];
        ew = rq_write[w];
        ed = ew ? rq_wdata[w] : '0;
        es = ew ? rq_strb[w] : '0;
        ep = rq_prot[w];
        chk("grant_ready", req_ready_o, 64'd1 << w);
        @(posedge clk); #1;
        case (post_mode)
            0: rq_valid[w] = 1'b0;
            1: ;
            2: rq_valid = '0;
            default: begin
                rq_valid[w] = ($urandom_range(0, 3) != 0);
                if (rq_valid[w]) rand_req(w);
                for (int k = 0; k < N; k++)
                    if (k != w && !rq_valid[k] && $urandom_range(0, 2) == 0) begin
                        rq_valid[k] = 1'b1;
                        rand_req(k);
                    end
            end
        endcase
        pready_i = (waits == 0);
        prdata_i = rd;
        pslverr_i = err;
        apply();
        #1;
        chk("setup_psel_en", {psel_o, penable_o}, 2'b10);
        chk("setup_addr", paddr_o, ea);
        chk("setup_ctl", {pwrite_o, pprot_o, pstrb_o}, {ew, ep, es});
        chk("setup_wdata", pwdata_o, ed);
        chk("setup_ready_rsp", {req_ready_o, rsp_valid_o}, 0);
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            pready_i  = (i == waits);
            prdata_i  = (i == waits) ? rd : $urandom;
            pslverr_i = (i == waits) ? err : 1'($urandom);
            #1;
            chk("access_psel_en", {psel_o, penable_o}, 2'b11);
            chk("access_addr", paddr_o, ea);
            chk("access_ctl", {pwrite_o, pprot_o, pstrb_o, pwdata_o}, {ew, ep, es, ed});
            chk("access_ready", req_ready_o, 0);
        end
        @(posedge clk); #1;
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom);
        #1;
        chk("rsp_valid", rsp_valid_o, 64'd1 << w);
        chk("rsp_rdata", rsp_rdata_o, ew ? 32'h0 : rd);
        chk("rsp_slverr", rsp_slverr_o, err);
        chk("rsp_psel_drop", {psel_o, penable_o}, 2'b00);
        last_model = w;
    endtask

    task automatic idle_step();
        chk("idle_ready", req_ready_o, 0);
        @(posedge clk); #1;
        chk("idle_rsp", {rsp_valid_o, psel_o}, 0);
        for (int k = 0; k < N; k++)
            if ($urandom_range(0, 1) == 1) begin
                rq_valid[k] = 1'b1;
                rand_req(k);
            end
        apply();
        #1;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        rst_i = 1'b1;
        pready_i = 1'b0;
        prdata_i = '0;
        pslverr_i = 1'b0;
        rq_valid = '1;
        for (int k = 0; k < N; k++) rand_req(k);
        apply();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_apb", {psel_o, penable_o, pwrite_o, paddr_o, pprot_o, pstrb_o}, 0);
        chk("rst_wdata", pwdata_o, 0);
        chk("rst_rsp", {rsp_valid_o, rsp_slverr_o, rsp_rdata_o}, 0);
        chk("rst_ready", req_ready_o, 0);

        // Round robin from reset with every requester continuously valid.
        rst_i = 1'b0;
        last_model = N - 1;
        post_mode = 1;
        #1;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) post_mode = 2;
            do_xfer(order[g], 0, 1'b0, $urandom);
        end
        chk("rr_idle_ready", req_ready_o, 0);

        // Single zero-wait write from requester 2.
        post_mode = 0;
        set_req(2, 1'b1, 32'h0000_4010, 32'hDEAD_BEEF);
        rq_valid = 4'b0100;
        apply();
        #1;
        do_xfer(2, 0, 1'b0, 32'h0BAD_F00D);

        // Read with five wait states from requester 0.
        set_req(0, 1'b0, 32'h0000_3000, 32'h5555_AAAA);
        rq_valid = 4'b0001;
        apply();
        #1;
        do_xfer(0, 5, 1'b0, 32'h1234_5678);

        // Slave error on a write from requester 3.
        set_req(3, 1'b1, 32'h0000_7004, 32'h0F0F_0F0F);
        rq_valid = 4'b1000;
        apply();
        #1;
        do_xfer(3, 1, 1'b1, $urandom);

        // Reset during ACCESS, with pready arriving in the same cycle.
        set_req(0, 1'b0, 32'h0000_5000, 32'h0);
        rq_valid = 4'b0001;
        apply();
        #1;
        chk("abort_grant", req_ready_o, 4'b0001);
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'h0000_5100, 32'h1111_2222);
        rq_valid = 4'b0011;
        apply();
        #1;
        chk("abort_setup", {psel_o, penable_o}, 2'b10);
        @(posedge clk); #1;
        chk("abort_access", {psel_o, penable_o}, 2'b11);
        rst_i = 1'b1;
        pready_i = 1'b1;
        prdata_i = 32'hA5A5_A5A5;
        #1;
        @(posedge clk); #1;
        chk("abort_psel", {psel_o, penable_o}, 2'b00);
        chk("abort_rsp", rsp_valid_o, 0);
        rst_i = 1'b0;
        last_model = N - 1;
        #1;
        chk("abort_rsp_after", rsp_valid_o, 0);
        post_mode = 2;
        do_xfer(rr_pick(), 0, 1'b0, $urandom);
        chk("abort_winner_was_0", last_model, 0);

        // ACCESS with pready held low.
        post_mode = 0;
        set_req(1, 1'b0, 32'h0000_6000, 32'h0);
        rq_valid = 4'b0010;
        apply();
        #1;
`ifdef APB_ARB_TIMEOUT_EN
        chk("tmo_grant", req_ready_o, 4'b0010);
        @(posedge clk); #1;
        rq_valid = '0;
        pready_i = 1'b0;
        apply();
        #1;
        chk("tmo_setup", {psel_o, penable_o}, 2'b10);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            prdata_i = $urandom;
            #1;
            chk("tmo_access", {psel_o, penable_o}, 2'b11);
        end
        @(posedge clk); #1;
        #1;
        chk("tmo_psel", {psel_o, penable_o}, 2'b00);
        chk("tmo_rsp", {rsp_valid_o, rsp_slverr_o}, {4'b0010, 1'b1});
        chk("tmo_rdata", rsp_rdata_o, 0);
        last_model = 1;
`else
        do_xfer(1, 120, 1'b0, 32'hCAFE_0001);
`endif

        // Randomized traffic against the round-robin model.
        rq_valid = '0;
        apply();
        post_mode = 3;
        #1;
        for (int t = 0; t < 80; t++) begin
            if (rq_valid == '0) idle_step();
            else do_xfer(rr_pick(), $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
